// File: rtl/shl_iter_seq_pkg.sv
// -----------------------------------------------------------------------------
// shl_iter_seq_pkg
//   Shared definitions for the iterative left shifter:
//     - FSM state encoding (IDLE / SHIFT / DONE)
//     - default operand and shift-amount widths
//     - small helpers used by the top-level control path
// -----------------------------------------------------------------------------
package shl_iter_seq_pkg;

   // Fixed 2-bit encoding so that state values are stable across builds and
   // easy to recognise on a waveform.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } shl_state_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_AMT_W = 3;

   // Next state out of IDLE: a zero amount skips the shift loop entirely.
   function automatic shl_state_t idle_next(input logic amt_is_zero);
      return amt_is_zero ? ST_DONE : ST_SHIFT;
   endfunction

   // Overflow accumulation: remember any 1 that leaves through the MSB.
   function automatic logic ovf_accum(input logic ovf_prev, input logic msb);
      return ovf_prev | msb;
   endfunction

endpackage : shl_iter_seq_pkg

// File: rtl/shl_iter_seq_shl1_stage.sv
// -----------------------------------------------------------------------------
// shl1_stage
//   Combinational one-step left shift with select.
//     sel = 0 : y = a
//     sel = 1 : y = {a[WIDTH-2:0], 1'b0}   (LSB zero-filled, MSB discarded)
// Ports
//   a    in   WIDTH  operand
//   sel  in   1      shift enable
//   y    out  WIDTH  result
// -----------------------------------------------------------------------------
module shl1_stage #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] shifted;

   assign shifted = {a[WIDTH-2:0], 1'b0};
   assign y       = sel ? shifted : a;

endmodule : shl1_stage

// File: rtl/shl_iter_seq.sv
// -----------------------------------------------------------------------------
// shl_iter_seq
//   Sequential multi-bit left shifter. One operand/amount pair is accepted over
//   a valid/ready handshake, shifted left by one bit per clock (zero-filling
//   the LSB) and returned with an overflow flag over a second valid/ready
//   handshake. Amounts >= WIDTH are legal and still cost one cycle per bit.
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand/amount valid
//   in_ready   out  1      block can accept (IDLE only)
//   in_data    in   WIDTH  operand
//   in_amt     in   AMT_W  number of single-bit left shifts
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   out_data   out  WIDTH  shifted result, 0 when out_valid=0
//   out_ovf    out  1      a 1 was shifted out of the MSB, 0 when out_valid=0
//   busy       out  1      operation in progress (SHIFT or DONE)
// -----------------------------------------------------------------------------
module shl_iter_seq
   import shl_iter_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMT_W = DEF_AMT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             busy
);

   shl_state_t       state_q;
   logic [WIDTH-1:0] data_q;
   logic [AMT_W-1:0] cnt_q;
   logic             ovf_q;
   logic [WIDTH-1:0] data_shl1;
   logic             last_step;

   // Single shift-by-one stage; the FSM only commits its output while in
   // SHIFT, so the select can stay permanently enabled.
   shl1_stage #(
      .WIDTH (WIDTH)
   ) u_shl1 (
      .a   (data_q),
      .sel (1'b1),
      .y   (data_shl1)
   );

   assign last_step = (cnt_q == AMT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         // Aborts any operation in flight; nothing is reported downstream.
         state_q <= ST_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  data_q  <= in_data;
                  cnt_q   <= in_amt;
                  ovf_q   <= 1'b0;
                  state_q <= idle_next(in_amt == '0);
               end
            end
            ST_SHIFT: begin
               // The MSB about to be discarded is folded into the flag in the
               // same cycle it leaves data_q.
               ovf_q  <= ovf_accum(ovf_q, data_q[WIDTH-1]);
               data_q <= data_shl1;
               cnt_q  <= cnt_q - AMT_W'(1);
               if (last_step) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Result holds until the consumer takes it; in_ready only
               // returns after this edge, so there is no out_ready->in_ready
               // combinational path.
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // All handshake outputs decode the state register only: nothing from in_*
   // or out_ready reaches them combinationally.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

   // Intermediate shift values never appear on the result port.
   assign out_data  = data_q & {WIDTH{out_valid}};
   assign out_ovf   = ovf_q & out_valid;

endmodule : shl_iter_seq
